buffer_reader: RTL and testbench

BUFFER_READER -- requirements
Module: buffer_reader

---
 rtl/buffer_reader.sv | 110 +++++++++++
 tb/tb_buffer_reader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_reader.sv
// buffer_reader: drains packets (header, size, payload) from an attached FIFO.
// It requests a route from the switch control, then forwards each flit downstream
// with a valid/ack handshake.
module buffer_reader #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         head,
    input  logic [$clog2(DEPTH):0]   counter,
    output logic                     pull,
    output logic                     h,
    input  logic                     ack_h,
    output logic                     data_av,
    output logic [WIDTH-1:0]         data_out,
    input  logic                     data_ack,
    output logic                     sender
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HDR,
        SIZE,
        PAYLOAD,
        END
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_remaining;
    logic [WIDTH-1:0] w_remaining_next;
    logic             w_not_empty;
    logic             w_in_packet;
    logic             w_transfer;

    assign w_not_empty = (counter != '0);
    assign w_in_packet = (r_state == HDR) || (r_state == SIZE) || (r_state == PAYLOAD);
    // An empty FIFO masks data_av, so a pop can never be issued on an empty FIFO.
    assign w_transfer  = w_in_packet && w_not_empty && data_ack;

    // Output decode: all outputs are pure functions of state and inputs, so the
    // asynchronous reset of the state clears them without waiting for a clock edge.
    always_comb begin
        h        = (r_state == REQ);
        sender   = w_in_packet;
        data_av  = w_in_packet && w_not_empty;
        pull     = w_transfer;
        data_out = head;
    end

    // State and payload counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
        end
    end

    // Next-state and remaining-count logic.
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        unique case (r_state)
            IDLE: begin
                if (w_not_empty) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (ack_h) begin
                    w_state_next = HDR;
                end
            end
            HDR: begin
                if (w_transfer) begin
                    w_state_next = SIZE;
                end
            end
            SIZE: begin
                if (w_transfer) begin
                    w_remaining_next = head;
                    w_state_next     = (head == '0) ? END : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (w_transfer) begin
                    // Saturating decrement; the last payload flit closes the packet.
                    if (r_remaining > WIDTH'(1)) begin
                        w_remaining_next = r_remaining - WIDTH'(1);
                    end else begin
                        w_remaining_next = '0;
                        w_state_next     = END;
                    end
                end
            end
            END: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_buffer_reader.sv
// tb_buffer_reader: directed and randomized checks of buffer_reader against a
// packet-level reference model (FIFO array, expected-flit queue, packet lengths).
`timescale 1ns/1ps
module tb_buffer_reader;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int CW = $clog2(D) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  head;
    logic [CW-1:0] counter;
    logic          pull;
    logic          h;
    logic          ack_h = 1'b0;
    logic          data_av;
    logic [W-1:0]  data_out;
    logic          data_ack = 1'b0;
    logic          sender;

    always #5 clock = ~clock;

    // FIFO model: written by the stimulus, popped on pull.
    logic [W-1:0] mem [0:63];
    int unsigned  wr = 0;
    int unsigned  rd = 0;
    assign counter = CW'(wr - rd);
    assign head    = mem[rd[5:0]];

    always @(posedge clock) begin
        if (pull) rd <= rd + 1;
    end

    buffer_reader #(.WIDTH(W), .DEPTH(D)) dut (
        .clock    (clock),
        .reset    (reset),
        .head     (head),
        .counter  (counter),
        .pull     (pull),
        .h        (h),
        .ack_h    (ack_h),
        .data_av  (data_av),
        .data_out (data_out),
        .data_ack (data_ack),
        .sender   (sender)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Route grant: asserts ack_h on the ack_delay-th cycle of a request.
    int ack_fixed = 3;
    int ack_delay = 3;
    int hcnt      = 0;
    always @(negedge clock) begin
        if (reset || !h) begin
            hcnt  = 0;
            ack_h = 1'b0;
        end else begin
            if (hcnt == 0) ack_delay = (ack_fixed > 0) ? ack_fixed : int'($urandom_range(1, 4));
            hcnt++;
            ack_h = (hcnt >= ack_delay);
        end
    end

    // Downstream acceptance: 0 = held level, 1 = random, 2 = toggling.
    int   dack_mode = 0;
    logic dack_val  = 1'b1;
    always @(negedge clock) begin
        case (dack_mode)
            0:       data_ack = dack_val;
            1:       data_ack = 1'($urandom_range(0, 1));
            default: data_ack = ~data_ack;
        endcase
    end

    // Reference model state.
    logic [W-1:0] exp_q [$];
    int           len_q [$];
    int   cyc = 0;
    bit   m_in = 0, just_ended = 0, prev_h = 0, prev_ack = 0, prev_idle = 0;
    logic [CW-1:0] prev_cnt = '0;
    int   h_run = 0, h_rise = 0, pkt_rise = 0;
    int   pkt_flits = 0, pkt_h = 0, pkt_sender = 0, first_x = 0, last_x = 0;
    int   last_flits = 0, last_h = 0, last_sender = 0, last_first = 0, last_last = 0;
    int   last_rise = 0, prev_end = 0, pkts_done = 0;

    // Monitor: samples 1 ns before each rising edge.
    always @(negedge clock) begin
        #4;
        cyc++;
        if (reset) begin
            check("rst_h", 32'(h), 0);
            check("rst_data_av", 32'(data_av), 0);
            check("rst_pull", 32'(pull), 0);
            check("rst_sender", 32'(sender), 0);
            m_in = 0; just_ended = 0; prev_h = 0; prev_ack = 0; prev_idle = 0;
            prev_cnt = '0; h_run = 0;
            exp_q.delete();
            len_q.delete();
        end else begin
            check("data_out", 32'(data_out), 32'(head));
            check("pull_rule", 32'(pull), 32'(data_av & data_ack));
            if (counter == '0) check("no_pull_empty", {30'd0, data_av, pull}, 0);
            if (!m_in) begin
                check("out_sender", 32'(sender), 0);
                check("out_data_av", 32'(data_av), 0);
                // A request follows an idle cycle that saw data, and holds until granted.
                check("h_seq", 32'(h), 32'((prev_h && !prev_ack) || (prev_idle && prev_cnt != '0)));
                if (h && !prev_h) h_rise = cyc;
                if (h) h_run++;
                prev_idle  = !just_ended && !h;
                just_ended = 0;
                if (h && ack_h) begin
                    m_in = 1; pkt_flits = 0; pkt_sender = 0;
                    pkt_h = h_run; h_run = 0; pkt_rise = h_rise;
                end
            end else begin
                check("in_h", 32'(h), 0);
                check("in_sender", 32'(sender), 1);
                check("in_data_av", 32'(data_av), 32'(counter != '0));
                pkt_sender++;
                if (pull) begin
                    if (exp_q.size() == 0 || len_q.size() == 0) begin
                        check("unexpected_pull", 32'(pull), 0);
                    end else begin
                        check("flit", 32'(data_out), 32'(exp_q.pop_front()));
                        if (pkt_flits == 0) first_x = cyc;
                        pkt_flits++;
                        last_x = cyc;
                        if (pkt_flits == len_q[0]) begin
                            void'(len_q.pop_front());
                            m_in = 0; just_ended = 1;
                            last_flits = pkt_flits; last_h = pkt_h; last_sender = pkt_sender;
                            last_first = first_x; prev_end = last_last; last_last = last_x;
                            last_rise = pkt_rise;
                            pkts_done++;
                        end
                    end
                end
                prev_idle = 0;
            end
            prev_h = h; prev_ack = ack_h; prev_cnt = counter;
        end
    end

    task automatic push(input logic [W-1:0] v);
        mem[wr[5:0]] = v;
        wr++;
        exp_q.push_back(v);
    endtask

    task automatic start_pkt(input logic [W-1:0] hdr, input logic [W-1:0] size);
        len_q.push_back(int'(size) + 2);
        push(hdr);
        push(size);
    endtask

    task automatic wait_pkts(input int target, input int budget);
        int n = 0;
        while (pkts_done < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("pkts_done", 32'(pkts_done), 32'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [W-1:0] flits [$];
        for (int i = 0; i < 64; i++) mem[i] = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Empty FIFO after reset: no request.
        repeat (4) @(negedge clock);
        check("idle_empty_h", 32'(h), 0);

        // Basic packet, grant after 3 request cycles.
        start_pkt(16'h0011, 16'h0002);
        push(16'hAAAA);
        push(16'hBBBB);
        wait_pkts(1, 60);
        check("t1_h_cycles", 32'(last_h), 3);
        check("t1_flits", 32'(last_flits), 4);
        check("t1_consecutive", 32'(last_last - last_first), 3);
        check("t1_sender_cycles", 32'(last_sender), 4);
        check("t1_sender_after", 32'(sender), 0);

        // Zero-size packet.
        start_pkt(16'h0022, 16'h0000);
        wait_pkts(2, 60);
        check("t2_flits", 32'(last_flits), 2);
        check("t2_sender_cycles", 32'(last_sender), 2);

        // Backpressure with toggling acceptance.
        dack_mode = 2;
        start_pkt(16'h0033, 16'h0004);
        for (int i = 0; i < 4; i++) push(16'hC000 + 16'(i));
        wait_pkts(3, 80);
        check("t3_flits", 32'(last_flits), 6);
        dack_mode = 0;
        @(negedge clock);

        // Starvation mid-payload.
        start_pkt(16'h0044, 16'h0003);
        push(16'h1111);
        repeat (12) @(negedge clock);
        check("t4_data_av", 32'(data_av), 0);
        check("t4_sender", 32'(sender), 1);
        check("t4_counter", 32'(counter), 0);
        check("t4_not_done", 32'(pkts_done), 3);
        push(16'h2222);
        push(16'h3333);
        wait_pkts(4, 40);
        check("t4_flits", 32'(last_flits), 5);

        // Back-to-back single-payload packets. The last transfer of the first packet
        // is sampled in cycle c; END is c+1, IDLE c+2, so h is first seen at c+3
        // (it rises on the second edge after the transfer edge).
        ack_fixed = 1;
        start_pkt(16'h0055, 16'h0001);
        push(16'h5555);
        start_pkt(16'h0066, 16'h0001);
        push(16'h6666);
        wait_pkts(6, 80);
        check("t5_h_gap", 32'(last_rise - prev_end), 3);

        // Reset mid-payload with remaining = 5 and flits pending.
        ack_fixed = 2;
        start_pkt(16'h0077, 16'h0008);
        for (int i = 0; i < 3; i++) push(16'h7000 + 16'(i));
        repeat (15) @(negedge clock);
        dack_val = 1'b0;
        @(negedge clock);
        push(16'h7003);
        push(16'h7004);
        repeat (2) @(negedge clock);
        check("t6_stalled_av", 32'(data_av), 1);
        #2;
        reset    = 1'b1;
        dack_val = 1'b1;
        #1;
        check("t6_async_h", 32'(h), 0);
        check("t6_async_av", 32'(data_av), 0);
        check("t6_async_pull", 32'(pull), 0);
        check("t6_async_sender", 32'(sender), 0);
        repeat (2) @(negedge clock);
        check("t6_no_pop", 32'(counter), 2);
        wr = rd;
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check("t6_idle_h", 32'(h), 0);
        check("t6_idle_sender", 32'(sender), 0);

        // First packet after reset.
        start_pkt(16'h0088, 16'h0001);
        push(16'h8888);
        wait_pkts(7, 60);
        check("t7_flits", 32'(last_flits), 3);

        // Randomized traffic.
        ack_fixed = 0;
        dack_mode = 1;
        base = pkts_done;
        for (int p = 0; p < 30; p++) begin
            int sz;
            sz = int'($urandom_range(0, 6));
            flits.delete();
            flits.push_back(16'($urandom));
            flits.push_back(16'(sz));
            for (int k = 0; k < sz; k++) flits.push_back(16'($urandom));
            for (int k = 0; k < flits.size(); k++) begin
                int tries = 0;
                @(negedge clock);
                while ((counter >= CW'(D) || $urandom_range(0, 2) == 0) && tries < 200) begin
                    @(negedge clock);
                    tries++;
                end
                if (k == 0) len_q.push_back(sz + 2);
                push(flits[k]);
            end
        end
        wait_pkts(base + 30, 4000);
        check("rand_queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
